// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage data-bus unit.
// Bus request/response structs, access size, FSM state and strobe helper.
package mem_access_pkg;

    localparam int AW = 64;
    localparam int DW = 64;

    typedef enum logic [1:0] {
        MSZ_B = 2'd0,
        MSZ_H = 2'd1,
        MSZ_W = 2'd2,
        MSZ_D = 2'd3
    } msize_t;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        msize_t        size;
        strobe_t       strobe;
        logic [DW-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic          addr_ok;
        logic          data_ok;
        logic [DW-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    function automatic strobe_t size_mask(input msize_t sz);
        case (sz)
            MSZ_B:   size_mask = 8'h01;
            MSZ_H:   size_mask = 8'h03;
            MSZ_W:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Pipeline-side request/result signals plus the data-bus request/response.
// slave = the memory unit, master = the pipeline/bus environment.
interface mem_access_if;
    import mem_access_pkg::*;

    logic          req_valid;
    logic          req_write;
    msize_t        req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          ack;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    logic [DW-1:0] rdata;
    logic          done;
    logic          stall;
    logic          misalign;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  ack, dresp,
        output dreq, rdata, done, stall, misalign
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output ack, dresp,
        input  dreq, rdata, done, stall, misalign
    );

endinterface

// File: rtl/mem_access_align.sv
// Byte-lane alignment: store data/strobe shift, load extract + extend, misalign detect.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]    addr_lo_i,
    input  msize_t        size_i,
    input  logic          unsigned_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] bus_rdata_i,
    output logic [DW-1:0] wdata_o,
    output strobe_t       strobe_o,
    output logic [DW-1:0] rdata_o,
    output logic          misalign_o
);

    logic [5:0]    shamt;
    logic [DW-1:0] shifted;

    assign shamt   = {addr_lo_i, 3'b000};
    assign shifted = bus_rdata_i >> shamt;

    always_comb begin
        wdata_o    = wdata_i << shamt;
        strobe_o   = size_mask(size_i) << addr_lo_i;
        rdata_o    = shifted;
        misalign_o = 1'b0;
        case (size_i)
            MSZ_B: begin
                rdata_o = {{56{~unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            MSZ_H: begin
                rdata_o    = {{48{~unsigned_i & shifted[15]}}, shifted[15:0]};
                misalign_o = addr_lo_i[0];
            end
            MSZ_W: begin
                rdata_o    = {{32{~unsigned_i & shifted[31]}}, shifted[31:0]};
                misalign_o = |addr_lo_i[1:0];
            end
            default: begin
                rdata_o    = shifted;
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage data-bus unit: one dreq per load/store, extended load result to MEM/WB.
// Latency: issue at t, dreq.valid at t+1, data_ok at t+k, done at t+k+1 (>=3 cycles).
// Backpressure: stalls the pipeline until the access completes; holds done/rdata until ack.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);

    mem_state_t    state_q, state_d;
    logic [AW-1:0] addr_q;
    msize_t        size_q;
    logic          write_q;
    logic          unsigned_q;
    strobe_t       strobe_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          in_idle;
    logic          issue;
    logic [2:0]    al_addr;
    msize_t        al_size;
    logic          al_unsigned;
    logic [DW-1:0] al_wdata;
    strobe_t       al_strobe;
    logic [DW-1:0] al_rdata;
    logic          al_misalign;
    logic          unused_addr_ok;

    assign unused_addr_ok = bus.dresp.addr_ok;
    assign in_idle        = (state_q == IDLE);

    // Live request drives the aligner in IDLE; captured op drives it while a response is awaited.
    assign al_addr     = in_idle ? bus.req_addr[2:0] : addr_q[2:0];
    assign al_size     = in_idle ? bus.req_size      : size_q;
    assign al_unsigned = in_idle ? bus.req_unsigned  : unsigned_q;

    mem_align u_align (
        .addr_lo_i   (al_addr),
        .size_i      (al_size),
        .unsigned_i  (al_unsigned),
        .wdata_i     (bus.req_wdata),
        .bus_rdata_i (bus.dresp.data),
        .wdata_o     (al_wdata),
        .strobe_o    (al_strobe),
        .rdata_o     (al_rdata),
        .misalign_o  (al_misalign)
    );

    assign issue = in_idle & bus.req_valid & ~al_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            size_q     <= MSZ_B;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            strobe_q   <= '0;
            data_q     <= '0;
        end else if (issue) begin
            addr_q     <= bus.req_addr;
            size_q     <= bus.req_size;
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            strobe_q   <= bus.req_write ? al_strobe : '0;
            data_q     <= bus.req_write ? al_wdata  : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.dresp.data_ok) begin
                    state_d = DONE;
                    rdata_d = write_q ? '0 : al_rdata;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.dreq.valid  = (state_q == REQ);
        bus.dreq.addr   = addr_q;
        bus.dreq.size   = size_q;
        bus.dreq.strobe = strobe_q;
        bus.dreq.data   = data_q;
        bus.rdata       = rdata_q;
        bus.done        = (state_q == DONE);
        bus.stall       = issue | (state_q == REQ);
        bus.misalign    = bus.req_valid & al_misalign;
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads/stores with hand-computed alignment and extension.
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_access_if ifc ();

    mem_access dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge. Response arrives in the k-th REQ cycle; ack held off ack_wait DONE cycles.
    task automatic run_op(input string tag, input logic wr, input msize_t sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input int k,
                          input logic [63:0] bus_data, input logic [7:0] exp_strb,
                          input logic [63:0] exp_data, input logic [63:0] exp_rdata,
                          input int ack_wait);
        ifc.req_valid    = 1'b1;
        ifc.req_write    = wr;
        ifc.req_size     = sz;
        ifc.req_unsigned = uns;
        ifc.req_addr     = addr;
        ifc.req_wdata    = wdata;
        #1;
        chk({tag, ".issue_stall"}, 64'(ifc.stall), 64'd1);
        chk({tag, ".issue_valid"}, 64'(ifc.dreq.valid), 64'd0);
        chk({tag, ".issue_misalign"}, 64'(ifc.misalign), 64'd0);
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            if (j == k) begin
                ifc.dresp.data_ok = 1'b1;
                ifc.dresp.data    = bus_data;
            end
            #1;
            chk({tag, ".req_valid"}, 64'(ifc.dreq.valid), 64'd1);
            chk({tag, ".req_addr"}, ifc.dreq.addr, addr);
            chk({tag, ".req_size"}, 64'(ifc.dreq.size), 64'(sz));
            chk({tag, ".req_strobe"}, 64'(ifc.dreq.strobe), 64'(exp_strb));
            if (wr) chk({tag, ".req_data"}, ifc.dreq.data, exp_data);
            chk({tag, ".req_stall"}, 64'(ifc.stall), 64'd1);
            chk({tag, ".req_done"}, 64'(ifc.done), 64'd0);
        end
        @(negedge clk);
        ifc.dresp.data_ok = 1'b0;
        ifc.dresp.data    = ~bus_data;
        for (int j = 0; j <= ack_wait; j++) begin
            if (j == ack_wait) begin
                ifc.ack       = 1'b1;
                ifc.req_valid = 1'b0;
            end
            #1;
            chk({tag, ".done"}, 64'(ifc.done), 64'd1);
            chk({tag, ".done_stall"}, 64'(ifc.stall), 64'd0);
            chk({tag, ".rdata"}, ifc.rdata, exp_rdata);
            chk({tag, ".done_valid"}, 64'(ifc.dreq.valid), 64'd0);
            @(negedge clk);
        end
        ifc.ack = 1'b0;
        #1;
        chk({tag, ".after_done"}, 64'(ifc.done), 64'd0);
        chk({tag, ".after_stall"}, 64'(ifc.stall), 64'd0);
        chk({tag, ".after_valid"}, 64'(ifc.dreq.valid), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        ifc.req_valid    = 1'b0;
        ifc.req_write    = 1'b0;
        ifc.req_size     = MSZ_B;
        ifc.req_unsigned = 1'b0;
        ifc.req_addr     = '0;
        ifc.req_wdata    = '0;
        ifc.ack          = 1'b0;
        ifc.dresp        = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.valid", 64'(ifc.dreq.valid), 64'd0);
        chk("rst.addr", ifc.dreq.addr, 64'd0);
        chk("rst.strobe", 64'(ifc.dreq.strobe), 64'd0);
        chk("rst.data", ifc.dreq.data, 64'd0);
        chk("rst.rdata", ifc.rdata, 64'd0);
        chk("rst.done", 64'(ifc.done), 64'd0);
        chk("rst.stall", 64'(ifc.stall), 64'd0);
        chk("rst.misalign", 64'(ifc.misalign), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("lw", 1'b0, MSZ_W, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 2,
               64'h8765_4321_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0);
        run_op("sb", 1'b1, MSZ_B, 1'b0, 64'h0000_0000_1000_0003, 64'h0000_0000_0000_00AB, 1,
               64'h1122_3344_5566_7788, 8'h08, 64'h0000_0000_AB00_0000, 64'h0, 0);
        run_op("sh", 1'b1, MSZ_H, 1'b0, 64'h0000_0000_1000_0002, 64'h0000_0000_0000_1234, 1,
               64'h0, 8'h0C, 64'h0000_0000_1234_0000, 64'h0, 0);
        run_op("sd", 1'b1, MSZ_D, 1'b0, 64'h0000_0000_1000_0008, 64'h0123_4567_89AB_CDEF, 2,
               64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0);

        // Misaligned halfword: flagged, no stall, no bus access.
        ifc.req_valid    = 1'b1;
        ifc.req_write    = 1'b0;
        ifc.req_size     = MSZ_H;
        ifc.req_unsigned = 1'b0;
        ifc.req_addr     = 64'h0000_0000_1000_0001;
        #1;
        chk("lh_mis.misalign", 64'(ifc.misalign), 64'd1);
        chk("lh_mis.stall", 64'(ifc.stall), 64'd0);
        @(negedge clk);
        #1;
        chk("lh_mis.valid", 64'(ifc.dreq.valid), 64'd0);
        chk("lh_mis.done", 64'(ifc.done), 64'd0);
        chk("lh_mis.stall2", 64'(ifc.stall), 64'd0);
        ifc.req_valid = 1'b0;
        #1;
        chk("lh_mis.clear", 64'(ifc.misalign), 64'd0);
        @(negedge clk);

        run_op("lbu", 1'b0, MSZ_B, 1'b1, 64'h0000_0000_2000_0007, 64'h0, 3,
               64'hF011_2233_4455_6677, 8'h00, 64'h0, 64'h0000_0000_0000_00F0, 0);
        run_op("lb", 1'b0, MSZ_B, 1'b0, 64'h0000_0000_2000_0005, 64'h0, 1,
               64'h0000_9A00_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF9A, 0);
        run_op("lh", 1'b0, MSZ_H, 1'b0, 64'h0000_0000_2000_0006, 64'h0, 1,
               64'h8001_0000_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0);
        run_op("ld", 1'b0, MSZ_D, 1'b0, 64'h0000_0000_2000_0018, 64'h0, 2,
               64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1);
        run_op("lwu_slow", 1'b0, MSZ_W, 1'b1, 64'h0000_0000_3000_000C, 64'h0, 10,
               64'h9ABC_DEF0_0000_0000, 8'h00, 64'h0, 64'h0000_0000_9ABC_DEF0, 2);

        // Reset in the middle of an outstanding access.
        ifc.req_valid    = 1'b1;
        ifc.req_write    = 1'b0;
        ifc.req_size     = MSZ_D;
        ifc.req_unsigned = 1'b0;
        ifc.req_addr     = 64'h0000_0000_4000_0010;
        @(negedge clk);
        #1;
        chk("rst_mid.pre_valid", 64'(ifc.dreq.valid), 64'd1);
        reset         = 1'b0;
        ifc.req_valid = 1'b0;
        #1;
        chk("rst_mid.valid", 64'(ifc.dreq.valid), 64'd0);
        chk("rst_mid.stall", 64'(ifc.stall), 64'd0);
        chk("rst_mid.rdata", ifc.rdata, 64'd0);
        @(negedge clk);
        reset             = 1'b1;
        ifc.dresp.data_ok = 1'b1;
        ifc.dresp.data    = 64'h5555_AAAA_5555_AAAA;
        #1;
        chk("rst_mid.idle_valid", 64'(ifc.dreq.valid), 64'd0);
        chk("rst_mid.idle_done", 64'(ifc.done), 64'd0);
        @(negedge clk);
        ifc.dresp.data_ok = 1'b0;
        #1;
        chk("rst_mid.no_done", 64'(ifc.done), 64'd0);
        chk("rst_mid.no_stall", 64'(ifc.stall), 64'd0);
        chk("rst_mid.rdata_zero", ifc.rdata, 64'd0);
        @(negedge clk);

        run_op("ld_after_rst", 1'b0, MSZ_D, 1'b0, 64'h0000_0000_4000_0010, 64'h0, 1,
               64'h0102_0304_0506_0708, 8'h00, 64'h0, 64'h0102_0304_0506_0708, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
